nibble2text_tx: RTL and testbench

Serializing transmitter that turns a binary word into a stream of ASCII hex characters. It emits the most-significant nibble first, then an optional line-feed terminator. It is the transmit counterpart of the team's ASCII-digit-to-nibble decoder and drives a character sink such as a UART TX FIFO or a simulation console. Upstream and downstream both use valid/ready handshakes.

---
 rtl/text_pkg.sv | 17 +
 rtl/nibble2ascii.sv | 24 ++
 rtl/nibble2text_tx.sv | 97 +++++++++
 tb/tb_nibble2text_tx.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_pkg.sv
// Shared constants for the hex text printers.
//   ASCII_*    : character codes used when rendering nibbles and line ends
//   tx_state_e : state encoding of the word-to-text transmitter
package text_pkg;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_UA = 8'h41;
    localparam logic [7:0] ASCII_LA = 8'h61;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIGIT = 2'd1,
        TERM  = 2'd2
    } tx_state_e;

endpackage

// File: rtl/nibble2ascii.sv
// Combinational nibble to ASCII hex digit.
//   nibble : 4-bit value 0..15
//   ascii  : '0'..'9', then 'A'..'F' (UPPER=1) or 'a'..'f' (UPPER=0)
module nibble2ascii
    import text_pkg::*;
#(
    parameter bit UPPER = 1'b1
) (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    logic [7:0] alpha_base;

    always_comb begin
        alpha_base = UPPER ? ASCII_UA : ASCII_LA;
        if (nibble < 4'd10) begin
            ascii = ASCII_0 + {4'd0, nibble};
        end else begin
            ascii = alpha_base + {4'd0, nibble} - 8'd10;
        end
    end

endmodule

// File: rtl/nibble2text_tx.sv
// Serializes a binary word into ASCII hex characters, MS nibble first,
// optionally followed by a line feed.
//   clk, rst_b            : clock, asynchronous active-low reset
//   in_data/valid/ready   : upstream word handshake (accepted only in IDLE)
//   out_char/valid/ready  : downstream character handshake
//   busy                  : a word is in flight (!in_ready)
module nibble2text_tx
    import text_pkg::*;
#(
    parameter int unsigned NIBBLES = 4,
    parameter bit          EOL_EN  = 1'b1,
    parameter bit          UPPER   = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic [4*NIBBLES-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [7:0]           out_char,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy
);

    localparam int unsigned W     = 4 * NIBBLES;
    localparam int unsigned CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

    tx_state_e        state_q, state_d;
    logic [W-1:0]     shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [7:0]       digit_char;

    nibble2ascii #(
        .UPPER(UPPER)
    ) u_map (
        .nibble(shreg_q[W-1 -: 4]),
        .ascii (digit_char)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_char  = 8'h00;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    shreg_d = in_data;
                    cnt_d   = '0;
                    state_d = DIGIT;
                end
            end
            DIGIT: begin
                out_valid = 1'b1;
                out_char  = digit_char;
                if (out_ready) begin
                    if (cnt_q == LAST) begin
                        state_d = EOL_EN ? TERM : IDLE;
                    end else begin
                        shreg_d = shreg_q << 4;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end
            TERM: begin
                out_valid = 1'b1;
                out_char  = ASCII_LF;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = ~in_ready;

endmodule

// File: tb/tb_nibble2text_tx.sv
module tb_nibble2text_tx;

    logic clk   = 1'b0;
    logic rst_b = 1'b0;

    always #5 clk = ~clk;

    // DUT A: NIBBLES=4, EOL_EN=1, UPPER=1
    logic [15:0] a_in_data = '0;
    logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b1, a_busy;
    logic [7:0]  a_out_char;
    // DUT B: NIBBLES=4, EOL_EN=0, UPPER=0
    logic [15:0] b_in_data = '0;
    logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1, b_busy;
    logic [7:0]  b_out_char;
    // DUT C: NIBBLES=1, EOL_EN=1, UPPER=1
    logic [3:0]  c_in_data = '0;
    logic        c_in_valid = 1'b0, c_in_ready, c_out_valid, c_out_ready = 1'b1, c_busy;
    logic [7:0]  c_out_char;
    // standalone nibble map
    logic [3:0]  nib = '0;
    logic [7:0]  asc_u, asc_l;

    nibble2text_tx #(.NIBBLES(4), .EOL_EN(1'b1), .UPPER(1'b1)) dut_a (
        .clk(clk), .rst_b(rst_b), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .out_char(a_out_char), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .busy(a_busy));

    nibble2text_tx #(.NIBBLES(4), .EOL_EN(1'b0), .UPPER(1'b0)) dut_b (
        .clk(clk), .rst_b(rst_b), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .out_char(b_out_char), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .busy(b_busy));

    nibble2text_tx #(.NIBBLES(1), .EOL_EN(1'b1), .UPPER(1'b1)) dut_c (
        .clk(clk), .rst_b(rst_b), .in_data(c_in_data), .in_valid(c_in_valid),
        .in_ready(c_in_ready), .out_char(c_out_char), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .busy(c_busy));

    nibble2ascii #(.UPPER(1'b1)) map_u (.nibble(nib), .ascii(asc_u));
    nibble2ascii #(.UPPER(1'b0)) map_l (.nibble(nib), .ascii(asc_l));

    int checks   = 0;
    int failures = 0;

    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    logic [7:0] q_c[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input int info);
        checks++;
        failures++;
        $display("FAIL %s info=%0d", name, info);
    endtask

    function automatic logic [7:0] ref_ascii(input int n, input bit up);
        if (n < 10) return 8'h30 + 8'(n);
        return (up ? 8'h41 : 8'h61) + 8'(n - 10);
    endfunction

    function automatic logic [3:0] decode_digit(input logic [7:0] c);
        return 4'(c - 8'h30);
    endfunction

    // Monitors: sampled on the falling edge, a transfer is valid&&ready
    // that will be taken on the next rising edge.
    logic       a_pv = 1'b0, a_pr = 1'b0;
    logic [7:0] a_pc = '0;
    always @(negedge clk) begin
        if (!rst_b) begin
            a_pv = 1'b0;
            a_pr = 1'b0;
        end else begin
            if (a_pv && !a_pr) begin
                chk("a_hold_valid", a_out_valid, 1);
                chk("a_hold_char", a_out_char, a_pc);
            end
            if (a_out_valid && a_out_ready) begin
                if (q_a.size() == 0) fail_now("a_unexpected_char", a_out_char);
                else chk("a_char", a_out_char, q_a.pop_front());
            end
            a_pv = a_out_valid;
            a_pr = a_out_ready;
            a_pc = a_out_char;
        end
    end

    always @(negedge clk) begin
        if (rst_b && b_out_valid && b_out_ready) begin
            if (q_b.size() == 0) fail_now("b_unexpected_char", b_out_char);
            else chk("b_char", b_out_char, q_b.pop_front());
        end
    end

    always @(negedge clk) begin
        if (rst_b && c_out_valid && c_out_ready) begin
            if (q_c.size() == 0) fail_now("c_unexpected_char", c_out_char);
            else chk("c_char", c_out_char, q_c.pop_front());
        end
    end

    task automatic a_send(input logic [15:0] d);
        int n = 0;
        while (!a_in_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (!a_in_ready) fail_now("a_accept_timeout", n);
        a_in_data  = d;
        a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
    endtask

    task automatic b_send(input logic [15:0] d);
        int n = 0;
        while (!b_in_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (!b_in_ready) fail_now("b_accept_timeout", n);
        b_in_data  = d;
        b_in_valid = 1'b1;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
    endtask

    task automatic c_send(input logic [3:0] d);
        int n = 0;
        while (!c_in_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (!c_in_ready) fail_now("c_accept_timeout", n);
        c_in_data  = d;
        c_in_valid = 1'b1;
        @(posedge clk); #1;
        c_in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q_a.size() + q_b.size() + q_c.size() != 0 || !a_in_ready || !b_in_ready || !c_in_ready)
               && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 100) fail_now("drain_timeout", q_a.size() + q_b.size() + q_c.size());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    logic [15:0] junk [5] = '{16'hDEAD, 16'hBEEF, 16'hC0DE, 16'h0F0F, 16'h7777};
    logic [3:0]  pat = 4'b1001;

    initial begin
        #12 rst_b = 1'b1;
        #1;
        chk("rst_in_ready", a_in_ready, 1);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_char", a_out_char, 8'h00);
        chk("rst_busy", a_busy, 0);
        @(posedge clk); #1;

        // Basic word
        q_a.push_back(8'h31); q_a.push_back(8'h41); q_a.push_back(8'h33);
        q_a.push_back(8'h46); q_a.push_back(8'h0A);
        a_send(16'h1A3F);
        chk("t1_latency_valid", a_out_valid, 1);
        chk("t1_first_char", a_out_char, 8'h31);
        chk("t1_busy", a_busy, 1);
        repeat (4) begin @(posedge clk); #1; end
        chk("t1_lf_char", a_out_char, 8'h0A);
        chk("t1_ready_low_at_lf", a_in_ready, 0);
        @(posedge clk); #1;
        chk("t1_ready_back", a_in_ready, 1);
        chk("t1_idle_char", a_out_char, 8'h00);
        chk("t1_all_sent", q_a.size(), 0);

        // Lower case, no terminator
        q_b.push_back(8'h62); q_b.push_back(8'h65); q_b.push_back(8'h65); q_b.push_back(8'h66);
        b_send(16'hBEEF);
        repeat (3) begin @(posedge clk); #1; end
        chk("t2_last_char", b_out_char, 8'h66);
        @(posedge clk); #1;
        chk("t2_ready_back", b_in_ready, 1);
        chk("t2_no_lf_valid", b_out_valid, 0);
        chk("t2_all_sent", q_b.size(), 0);

        // Backpressure
        q_a.push_back(8'h30); q_a.push_back(8'h30); q_a.push_back(8'h30);
        q_a.push_back(8'h39); q_a.push_back(8'h0A);
        a_send(16'h0009);
        for (int k = 0; k < 40 && q_a.size() != 0; k++) begin
            a_out_ready = pat[k % 4];
            @(posedge clk); #1;
        end
        a_out_ready = 1'b1;
        drain();

        // Input ignored while busy
        chk("t4_ready_pre", a_in_ready, 1);
        q_a.push_back(8'h35); q_a.push_back(8'h36); q_a.push_back(8'h37);
        q_a.push_back(8'h38); q_a.push_back(8'h0A);
        a_in_data  = 16'h5678;
        a_in_valid = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            chk("t4_ready_low", a_in_ready, 0);
            a_in_data = junk[i];
            @(posedge clk); #1;
        end
        chk("t4_ready_back", a_in_ready, 1);
        q_a.push_back(8'h39); q_a.push_back(8'h41); q_a.push_back(8'h42);
        q_a.push_back(8'h43); q_a.push_back(8'h0A);
        a_in_data = 16'h9ABC;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        chk("t4_second_first", a_out_char, 8'h39);
        drain();

        // Reset mid-word
        q_a.push_back(8'h31); q_a.push_back(8'h32); q_a.push_back(8'h33);
        q_a.push_back(8'h34); q_a.push_back(8'h0A);
        a_send(16'h1234);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t5_third_char", a_out_char, 8'h33);
        #2 rst_b = 1'b0;
        #1;
        chk("t5_rst_valid", a_out_valid, 0);
        chk("t5_rst_char", a_out_char, 8'h00);
        chk("t5_rst_ready", a_in_ready, 1);
        q_a.delete();
        #4 rst_b = 1'b1;
        @(posedge clk); #1;
        chk("t5_ready_after", a_in_ready, 1);
        for (int i = 0; i < 4; i++) q_a.push_back(8'h46);
        q_a.push_back(8'h0A);
        a_send(16'hFFFF);
        drain();

        // Single-nibble instance
        q_c.push_back(8'h30); q_c.push_back(8'h0A);
        c_send(4'h0);
        chk("t6_zero", c_out_char, 8'h30);
        @(posedge clk); #1;
        chk("t6_lf", c_out_char, 8'h0A);
        @(posedge clk); #1;
        chk("t6_ready_back", c_in_ready, 1);
        q_c.push_back(8'h46); q_c.push_back(8'h0A);
        c_send(4'hF);
        drain();

        // Exhaustive nibble map and digit round trip
        for (int i = 0; i < 16; i++) begin
            nib = 4'(i);
            #1;
            chk("map_upper", asc_u, ref_ascii(i, 1'b1));
            chk("map_lower", asc_l, ref_ascii(i, 1'b0));
            if (i < 10) chk("roundtrip", decode_digit(asc_u), i);
        end
        chk("map_hand_A", {24'd0, asc_u}, 8'h46);
        chk("map_hand_a", {24'd0, asc_l}, 8'h66);

        chk("end_q_a", q_a.size(), 0);
        chk("end_q_b", q_b.size(), 0);
        chk("end_q_c", q_c.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
